// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bus between the 5-stage pipeline (master) and the hazard
// sequencer (slave). It carries the decode/execute/memory hazard sources and the
// stall, flush, bubble and status signals that go back to the pipeline registers.
interface pipeline_hazard_controller_if #(
  parameter int COUNTER_WIDTH = 16
);

  // Hazard sources observed in the pipeline
  logic [4:0]               decodeStageLHSReadRegisterIndex;
  logic [4:0]               decodeStageRHSReadRegisterIndex;
  logic [4:0]               executionStageWriteRegisterIndex;
  logic                     isExecutionStageMemoryReadOperation;
  logic                     isExecutionStageBranchTaken;
  logic                     memoryStageRequest;
  logic                     memoryReady;

  // Pipeline-register controls and status returned by the sequencer
  logic                     stallFetch;
  logic                     stallDecode;
  logic                     stallExecute;
  logic                     bubbleExecute;
  logic                     flushDecode;
  logic                     memoryTimeoutError;
  logic [COUNTER_WIDTH-1:0] stallCycleCount;
  logic [COUNTER_WIDTH-1:0] flushCount;

  // Pipeline side: presents hazard sources and consumes controls
  modport master (
    output decodeStageLHSReadRegisterIndex,
    output decodeStageRHSReadRegisterIndex,
    output executionStageWriteRegisterIndex,
    output isExecutionStageMemoryReadOperation,
    output isExecutionStageBranchTaken,
    output memoryStageRequest,
    output memoryReady,
    input  stallFetch,
    input  stallDecode,
    input  stallExecute,
    input  bubbleExecute,
    input  flushDecode,
    input  memoryTimeoutError,
    input  stallCycleCount,
    input  flushCount
  );

  // Sequencer side: consumes hazard sources and drives controls
  modport slave (
    input  decodeStageLHSReadRegisterIndex,
    input  decodeStageRHSReadRegisterIndex,
    input  executionStageWriteRegisterIndex,
    input  isExecutionStageMemoryReadOperation,
    input  isExecutionStageBranchTaken,
    input  memoryStageRequest,
    input  memoryReady,
    output stallFetch,
    output stallDecode,
    output stallExecute,
    output bubbleExecute,
    output flushDecode,
    output memoryTimeoutError,
    output stallCycleCount,
    output flushCount
  );

endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central hazard sequencer for the 5-stage core. Merges load-use detection,
// execute-stage branch redirects and data-memory wait states into one set of
// fetch/decode/execute stall, flush and bubble controls. A redirect that arrives
// while memory is stalling is parked in pendingFlush and applied on the cycle
// memory completes. Controls are combinational (same-cycle) from state + inputs;
// state and counters update on the next rising edge.
module pipeline_hazard_controller #(
  parameter int COUNTER_WIDTH = 16,
  parameter int MEM_TIMEOUT   = 64
) (
  input  logic                         clk,
  input  logic                         resetN,
  pipeline_hazard_controller_if.slave  hazardBus
);

  localparam int                       WAIT_WIDTH = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_WIDTH-1:0]    WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX  = '1;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazardState_t;

  hazardState_t             state;
  logic                     pendingFlush;
  logic [WAIT_WIDTH-1:0]    waitCnt;
  logic                     timeoutError;
  logic [COUNTER_WIDTH-1:0] stallCycleCountQ;
  logic [COUNTER_WIDTH-1:0] flushCountQ;

  logic loadUse;
  logic memWait;
  logic stallFetchC;
  logic stallDecodeC;
  logic stallExecuteC;
  logic bubbleExecuteC;
  logic flushDecodeC;

  // Hazard detection: register 0 is hardwired zero and never creates a dependency
  assign loadUse = hazardBus.isExecutionStageMemoryReadOperation
                && (hazardBus.executionStageWriteRegisterIndex != 5'd0)
                && ((hazardBus.executionStageWriteRegisterIndex == hazardBus.decodeStageLHSReadRegisterIndex)
                 || (hazardBus.executionStageWriteRegisterIndex == hazardBus.decodeStageRHSReadRegisterIndex));

  assign memWait = hazardBus.memoryStageRequest && !hazardBus.memoryReady;

  // Same-cycle control decode; priority memory wait > branch/deferred flush > load-use
  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    stallFetchC    = 1'b0;
    stallDecodeC   = 1'b0;
    stallExecuteC  = 1'b0;
    bubbleExecuteC = 1'b0;
    flushDecodeC   = 1'b0;
    // Controls are forced inactive while reset is asserted, even mid-operation
    if (resetN) begin
      case (state)
        RUN: begin
          if (memWait) begin
            stallFetchC   = 1'b1;
            stallDecodeC  = 1'b1;
            stallExecuteC = 1'b1;
          end else if (hazardBus.isExecutionStageBranchTaken) begin
            // The younger decode instruction is discarded, so load-use is moot
            flushDecodeC   = 1'b1;
            bubbleExecuteC = 1'b1;
          end else if (loadUse) begin
            stallFetchC    = 1'b1;
            stallDecodeC   = 1'b1;
            bubbleExecuteC = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Execute is frozen here, so the branch input is not looked at
          if (!hazardBus.memoryReady) begin
            stallFetchC   = 1'b1;
            stallDecodeC  = 1'b1;
            stallExecuteC = 1'b1;
          end else if (pendingFlush) begin
            flushDecodeC   = 1'b1;
            bubbleExecuteC = 1'b1;
          end else if (loadUse) begin
            stallFetchC    = 1'b1;
            stallDecodeC   = 1'b1;
            bubbleExecuteC = 1'b1;
          end
        end
        default: begin
          stallFetchC = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, deferred flush, wait timer, sticky timeout and saturating counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= RUN;
      pendingFlush     <= 1'b0;
      waitCnt          <= '0;
      timeoutError     <= 1'b0;
      stallCycleCountQ <= '0;
      flushCountQ      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (stallFetchC && (stallCycleCountQ != COUNT_MAX)) begin
        stallCycleCountQ <= stallCycleCountQ + 1'b1;
      end
      if (flushDecodeC && (flushCountQ != COUNT_MAX)) begin
        flushCountQ <= flushCountQ + 1'b1;
      end

      case (state)
        RUN: begin
          if (memWait) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
            // Redirect resolved during the stall is remembered, not dropped
            if (hazardBus.isExecutionStageBranchTaken) begin
              pendingFlush <= 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          if (hazardBus.memoryReady) begin
            state        <= RUN;
            waitCnt      <= '0;
            pendingFlush <= 1'b0;
          end else if (waitCnt != WAIT_LIMIT) begin
            // Error latches on the wait cycle that brings waitCnt to MEM_TIMEOUT
            waitCnt <= waitCnt + 1'b1;
            if (waitCnt == (WAIT_LIMIT - 1'b1)) begin
              timeoutError <= 1'b1;
            end
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign hazardBus.stallFetch         = stallFetchC;
  assign hazardBus.stallDecode        = stallDecodeC;
  assign hazardBus.stallExecute       = stallExecuteC;
  assign hazardBus.bubbleExecute      = bubbleExecuteC;
  assign hazardBus.flushDecode        = flushDecodeC;
  assign hazardBus.memoryTimeoutError = timeoutError;
  assign hazardBus.stallCycleCount    = stallCycleCountQ;
  assign hazardBus.flushCount         = flushCountQ;

endmodule
